return_stack_ctrl: RTL and testbench
====================================

# return_stack_ctrl

Sequencer sitting directly upstream of the team's LIFO stack block, turning decoder CALL/RET/FLUSH commands into stack push/pop strobes. Delivers popped return addresses to the PC-select stage over a valid/ready handshake. Flags overflow, underflow and illegal commands with sticky error bits. The LIFO is instantiated by the parent; this block only drives and observes its ports.

## Interface
- ADDR_W, 16, return-address width; equals the LIFO width.
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  decoder command present
- cmd_ready  out  1  command accepted at the edge when cmd_valid && cmd_ready
- cmd_op  in  2  00 CALL, 01 RET, 10 FLUSH, 11 reserved
- cmd_addr  in  ADDR_W  return address to save on CALL
- ret_valid  out  1  ret_addr/ret_fault valid
- ret_ready  in  1  PC stage consumes return address
- ret_addr  out  ADDR_W  popped return address
- ret_fault  out  1  RET issued on empty stack; ret_addr is 0
- flush_done  out  1  one-cycle pulse, stack emptied
- err_ovf, err_udf, err_ill  out  1 each  sticky: CALL while full, RET while empty, op 11
- err_clr  in  1  clears all sticky errors
- stk_data  out  ADDR_W  to LIFO data
- stk_push, stk_pop  out  1 each  to LIFO push/pop
- stk_q  in  ADDR_W  LIFO top-of-stack
- stk_empty, stk_full  in  1 each  LIFO flags, valid for the state after the last edge

## Operation
- LIFO contract relied on: stk_q holds the current top whenever stk_empty=0. A pop value is sampled from stk_q in the same cycle stk_pop is asserted. stk_push and stk_pop are never asserted together.
- States: IDLE, RET_HOLD, FLUSH. cmd_ready = (state==IDLE) && !reset.
- CALL accepted, stk_full=0: stk_push=1 and stk_data=cmd_addr combinationally in the accept cycle. Remain in IDLE; back-to-back CALLs every cycle are legal.
- CALL accepted, stk_full=1: no push; err_ovf set at the edge.
- RET accepted, stk_empty=0: stk_pop=1 in the accept cycle. At the edge: ret_addr<=stk_q, ret_fault<=0, ret_valid<=1, go to RET_HOLD.
- RET accepted, stk_empty=1: no pop. At the edge: ret_addr<=0, ret_fault<=1, ret_valid<=1, err_udf<=1, go to RET_HOLD.
- RET_HOLD: outputs stable. On ret_valid && ret_ready: ret_valid<=0, go to IDLE. The next command can be accepted one cycle later.
- FLUSH accepted: go to FLUSH. In FLUSH, stk_pop = !stk_empty each cycle. When stk_empty=1: flush_done=1 combinationally, no pop, go to IDLE.
- Op 11 accepted: err_ill set, no stack activity, stay in IDLE.
- Sticky errors: set has priority over err_clr in the same cycle.
- stk_data = cmd_addr at all times; only stk_push qualifies it.

## Timing
- Reset: state IDLE, ret_valid=0, ret_addr=0, ret_fault=0, all err_*=0. During the reset cycle stk_push=stk_pop=flush_done=0 and cmd_ready=0.
- Reset mid-RET_HOLD or mid-FLUSH: abandons the operation, with no further pops. The parent resets the LIFO in the same cycle.
- CALL latency: push strobe in the accept cycle; LIFO count and flags update at that edge.
- RET latency: ret_valid rises 1 cycle after accept. Minimum RET-to-RET spacing is 2 cycles with ret_ready held high.
- CALL immediately followed by RET: the RET pops the address just pushed, because stk_q reflects the push from the next cycle.
- FLUSH of N entries: N pop cycles, then a flush_done cycle. For N=0, flush_done occurs in the cycle after accept.
- Outputs ret_* are registered. stk_push, stk_pop, cmd_ready and flush_done are combinational from state, inputs and LIFO flags.

## Structure
- Shared package: cmd_op encodings (OP_CALL, OP_RET, OP_FLUSH, OP_RSVD) and state enum (ST_IDLE, ST_RET_HOLD, ST_FLUSH). Nested-call depth matches the LIFO depth parameter, which is set in the parent only.
- No sub-module; a single FSM plus output registers. The LIFO stays a sibling instance in the parent.

## Test plan
Bench: LIFO depth 4, ADDR_W 16.
- Reset, then CALL 0x0100, 0x0200, then RET, RET, each with ret_ready=1 -> ret_addr 0x0200 then 0x0100, ret_fault=0, no errors.
- Five back-to-back CALLs 0x0001..0x0005 -> four pushes; fifth cycle stk_push=0 and err_ovf=1; next RET returns 0x0004.
- RET on empty stack -> no stk_pop, ret_valid=1, ret_addr=0, ret_fault=1, err_udf=1; err_clr then clears err_udf.
- CALL 0x0A0A, RET with ret_ready held low 3 cycles -> ret_valid and ret_addr stable for 3 cycles, cmd_ready=0 throughout, IDLE one cycle after ret_ready.
- Three CALLs, then FLUSH -> exactly 3 stk_pop cycles, then a flush_done pulse, stk_empty=1. FLUSH on empty -> flush_done 1 cycle after accept.
- Op 11 -> err_ill=1, no stack strobes; reset asserted in RET_HOLD -> ret_valid=0 and IDLE the next cycle.

Source files
------------

// File: rtl/return_stack_ctrl_pkg.sv
// Shared encodings for the return-stack sequencer: decoder opcodes, FSM states
// and the sticky-error update rule.
package return_stack_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_CALL  = 2'b00,
    OP_RET   = 2'b01,
    OP_FLUSH = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RET_HOLD = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  // A new error event wins over a clear issued in the same cycle.
  function automatic logic sticky_next(input logic set, input logic clr, input logic q);
    return set | (q & ~clr);
  endfunction

endpackage

// File: rtl/return_stack_ctrl.sv
// Turns decoder CALL/RET/FLUSH commands into push/pop strobes for a sibling LIFO
// and hands popped return addresses to the PC-select stage over valid/ready.
module return_stack_ctrl
  import return_stack_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              ret_valid,
  input  logic              ret_ready,
  output logic [ADDR_W-1:0] ret_addr,
  output logic              ret_fault,
  output logic              flush_done,
  output logic              err_ovf,
  output logic              err_udf,
  output logic              err_ill,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] stk_data,
  output logic              stk_push,
  output logic              stk_pop,
  input  logic [ADDR_W-1:0] stk_q,
  input  logic              stk_empty,
  input  logic              stk_full
);

  state_e              state_q, state_d;
  logic                ret_valid_q, ret_valid_d;
  logic                ret_fault_q, ret_fault_d;
  logic [ADDR_W-1:0]   ret_addr_q, ret_addr_d;
  logic                err_ovf_q, err_udf_q, err_ill_q;
  logic                err_ovf_d, err_udf_d, err_ill_d;
  logic                ovf_set, udf_set, ill_set;
  cmd_op_e             op;

  assign op       = cmd_op_e'(cmd_op);
  // The LIFO only latches stk_data when stk_push qualifies it.
  assign stk_data = cmd_addr;

  always_comb begin
    state_d     = state_q;
    ret_valid_d = ret_valid_q;
    ret_fault_d = ret_fault_q;
    ret_addr_d  = ret_addr_q;
    ovf_set     = 1'b0;
    udf_set     = 1'b0;
    ill_set     = 1'b0;
    cmd_ready   = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    flush_done  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            unique case (op)
              OP_CALL: begin
                if (stk_full) ovf_set  = 1'b1;
                else          stk_push = 1'b1;
              end
              OP_RET: begin
                ret_valid_d = 1'b1;
                state_d     = ST_RET_HOLD;
                if (!stk_empty) begin
                  stk_pop     = 1'b1;
                  ret_addr_d  = stk_q;
                  ret_fault_d = 1'b0;
                end else begin
                  ret_addr_d  = '0;
                  ret_fault_d = 1'b1;
                  udf_set     = 1'b1;
                end
              end
              OP_FLUSH: state_d = ST_FLUSH;
              OP_RSVD:  ill_set = 1'b1;
            endcase
          end
        end
        ST_RET_HOLD: begin
          if (ret_valid_q && ret_ready) begin
            ret_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (stk_empty) begin
            flush_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            stk_pop = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign err_ovf_d = sticky_next(ovf_set, err_clr, err_ovf_q);
  assign err_udf_d = sticky_next(udf_set, err_clr, err_udf_q);
  assign err_ill_d = sticky_next(ill_set, err_clr, err_ill_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ret_valid_q <= 1'b0;
      ret_fault_q <= 1'b0;
      ret_addr_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_udf_q   <= 1'b0;
      err_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_valid_q <= ret_valid_d;
      ret_fault_q <= ret_fault_d;
      ret_addr_q  <= ret_addr_d;
      err_ovf_q   <= err_ovf_d;
      err_udf_q   <= err_udf_d;
      err_ill_q   <= err_ill_d;
    end
  end

  assign ret_valid = ret_valid_q;
  assign ret_fault = ret_fault_q;
  assign ret_addr  = ret_addr_q;
  assign err_ovf   = err_ovf_q;
  assign err_udf   = err_udf_q;
  assign err_ill   = err_ill_q;

endmodule

// File: tb/tb_return_stack_ctrl.sv
// Bench for return_stack_ctrl: depth-4 LIFO environment, queue-based reference
// stack, and a scoreboard monitor for the return-address channel.
module tb_return_stack_ctrl;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              ret_valid, ret_ready;
  logic [ADDR_W-1:0] ret_addr;
  logic              ret_fault, flush_done;
  logic              err_ovf, err_udf, err_ill, err_clr;
  logic [ADDR_W-1:0] stk_data, stk_q;
  logic              stk_push, stk_pop, stk_empty, stk_full;

  always #5 clock = ~clock;

  return_stack_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_addr(ret_addr), .ret_fault(ret_fault),
    .flush_done(flush_done),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_ill(err_ill), .err_clr(err_clr),
    .stk_data(stk_data), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_q(stk_q), .stk_empty(stk_empty), .stk_full(stk_full)
  );

  // Sibling LIFO as the parent would instantiate it
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [2:0]        cnt;
  always @(posedge clock) begin
    if (reset) cnt <= '0;
    else if (stk_push && cnt < 3'(DEPTH)) begin
      mem[cnt[1:0]] <= stk_data;
      cnt <= cnt + 3'd1;
    end else if (stk_pop && cnt != 0) cnt <= cnt - 3'd1;
  end
  assign stk_empty = (cnt == 0);
  assign stk_full  = (cnt == 3'(DEPTH));
  assign stk_q     = (cnt != 0) ? mem[2'(cnt - 3'd1)] : '0;

  // Reference model: plain stack of saved addresses plus sticky flags
  int unsigned       ref_stk[$];
  logic [ADDR_W:0]   exp_q[$];   // {fault, addr}
  bit                m_ovf, m_udf, m_ill;
  int                errors = 0;
  int                checks = 0;
  bit                rnd_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares each consumed return against the model
  always @(negedge clock) begin
    if (!reset && ret_valid && ret_ready) begin
      if (exp_q.size() == 0) chk("ret_unexpected", 1, 0);
      else begin
        logic [ADDR_W:0] e;
        e = exp_q.pop_front();
        chk("ret_addr", ret_addr, e[ADDR_W-1:0]);
        chk("ret_fault", ret_fault, e[ADDR_W]);
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic model_reset();
    ref_stk.delete(); exp_q.delete();
    m_ovf = 0; m_udf = 0; m_ill = 0;
  endtask

  task automatic check_errs(input string tag);
    chk({tag, "_ovf"}, err_ovf, m_ovf);
    chk({tag, "_udf"}, err_udf, m_udf);
    chk({tag, "_ill"}, err_ill, m_ill);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
    int budget = 100;
    int pops = 0;
    int exp_pops;
    bit ok = 0;
    cmd_valid = 1; cmd_op = op; cmd_addr = addr;
    while (budget > 0) begin
      @(negedge clock);
      if (cmd_ready) begin ok = 1; break; end
      step();
      if (rnd_mode) ret_ready = 1'($urandom_range(0, 1));
      budget--;
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 0;
      return;
    end
    chk("push_strobe", stk_push, (op == 2'b00) && (ref_stk.size() < DEPTH));
    chk("pop_strobe", stk_pop, (op == 2'b01) && (ref_stk.size() > 0));
    if (stk_push) chk("push_data", stk_data, addr);
    exp_pops = ref_stk.size();
    case (op)
      2'b00: if (ref_stk.size() < DEPTH) ref_stk.push_back(addr); else m_ovf = 1;
      2'b01: if (ref_stk.size() > 0) exp_q.push_back({1'b0, ADDR_W'(ref_stk.pop_back())});
             else begin exp_q.push_back({1'b1, {ADDR_W{1'b0}}}); m_udf = 1; end
      2'b10: ref_stk.delete();
      default: m_ill = 1;
    endcase
    step();
    cmd_valid = 0;
    if (op == 2'b10) begin
      budget = 20; ok = 0;
      while (budget > 0) begin
        @(negedge clock);
        if (flush_done) begin ok = 1; break; end
        pops += int'(stk_pop);
        step();
        budget--;
      end
      chk("flush_done_seen", ok, 1);
      chk("flush_pops", pops, exp_pops);
      chk("flush_empty", stk_empty, 1);
      step();
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1; step(); err_clr = 0;
    m_ovf = 0; m_udf = 0; m_ill = 0;
  endtask

  initial begin
    reset = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; ret_ready = 1; err_clr = 0;
    model_reset();
    step();
    @(negedge clock);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_push", stk_push, 0);
    chk("rst_pop", stk_pop, 0);
    chk("rst_flush_done", flush_done, 0);
    step();
    reset = 0;
    @(negedge clock);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_ret_addr", ret_addr, 0);
    chk("rst_ret_fault", ret_fault, 0);
    check_errs("rst");
    chk("idle_ready", cmd_ready, 1);
    step();

    // Nested call / return
    issue(2'b00, 16'h0100);
    issue(2'b00, 16'h0200);
    issue(2'b01, 0);
    issue(2'b01, 0);
    step();
    check_errs("nest");

    // Overflow on the fifth CALL, then drain
    for (int i = 1; i <= 5; i++) issue(2'b00, ADDR_W'(i));
    @(negedge clock); check_errs("ovf"); step();
    for (int i = 0; i < 4; i++) issue(2'b01, 0);
    step();

    // Underflow
    issue(2'b01, 0);
    step();
    @(negedge clock); check_errs("udf"); step();
    pulse_clr();
    @(negedge clock); check_errs("clr"); step();

    // Back-pressure on the return channel
    issue(2'b00, 16'h0A0A);
    ret_ready = 0;
    issue(2'b01, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hold_valid", ret_valid, 1);
      chk("hold_addr", ret_addr, 16'h0A0A);
      chk("hold_ready", cmd_ready, 0);
      step();
    end
    ret_ready = 1;
    step();
    @(negedge clock); chk("hold_release_idle", cmd_ready, 1); step();

    // Flush with three entries, then on an empty stack
    for (int i = 0; i < 3; i++) issue(2'b00, ADDR_W'(16'h0300 + i));
    issue(2'b10, 0);
    issue(2'b10, 0);

    // Reserved opcode
    issue(2'b11, 0);
    @(negedge clock); check_errs("ill"); step();

    // Reset while a return is being held
    issue(2'b00, 16'h1234);
    ret_ready = 0;
    issue(2'b01, 0);
    reset = 1;
    @(negedge clock);
    chk("rst_hold_pop", stk_pop, 0);
    chk("rst_hold_ready", cmd_ready, 0);
    model_reset();
    step();
    reset = 0; ret_ready = 1;
    @(negedge clock);
    chk("rst_hold_valid", ret_valid, 0);
    chk("rst_hold_idle", cmd_ready, 1);
    check_errs("rst_hold");
    step();

    // Randomized traffic with random back-pressure
    rnd_mode = 1;
    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 19);
      logic [1:0] op;
      if (r < 9) op = 2'b00; else if (r < 16) op = 2'b01; else if (r < 19) op = 2'b10; else op = 2'b11;
      issue(op, ADDR_W'($urandom));
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clock); check_errs("rnd"); step();
        pulse_clr();
      end
    end
    rnd_mode = 0;
    ret_ready = 1;
    repeat (3) step();
    @(negedge clock);
    check_errs("rnd_end");
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("lifo_depth", cnt, ref_stk.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
